// File: rtl/mips_mem_pkg.sv
// Shared types, widths and helpers for the instruction-fetch responder.
package mips_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the word index of a byte address falls inside a memory of depth words.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       depth);
    return 32'(addr[ADDR_W-1:2]) < depth;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x 32 word storage: one synchronous write port, one registered read port.
// A read and a write to the same word on the same edge return the old word.
module mem_word_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned INIT_NOP = 1,
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data
);

  // Contents survive reset; only the read register is cleared.
  logic [WORD_W-1:0] r_mem [DEPTH] =
    '{default: (INIT_NOP != 0) ? NOP_WORD : {WORD_W{1'bx}}};
  logic [WORD_W-1:0] r_rd_data;

  // Registered read; sees the pre-write contents on a same-word collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_idx];
    end
  end

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: accepts one fetch at a time and answers after a
// fixed LATENCY of wait cycles; independent load port writes program words.
module instr_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned INIT_NOP = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  input  logic [ADDR_W-1:0] Address,
  output logic              ReqReady,
  input  logic              Flush,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [WORD_W-1:0] Instruction,
  output logic              AddrError,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [WORD_W-1:0] LoadData
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_next_count;
  logic [IDX_W-1:0]   r_idx;
  logic               r_err;
  logic               r_req_ready;
  logic               r_resp_valid;

  logic               w_accept;
  logic               w_req_err;
  logic [IDX_W-1:0]   w_req_idx;
  logic               w_rd_en;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [WORD_W-1:0]  w_rd_data;
  logic               w_wr_en;
  logic               w_unused_load_lsbs;

  assign w_accept  = (r_state == IDLE) && r_req_ready && ReqValid && !Flush;
  assign w_req_err = (Address[1:0] != 2'b00) || !addr_in_range(Address, DEPTH);
  assign w_req_idx = Address[IDX_W+1:2];

  // Loads during reset are dropped; out-of-range loads never alias into storage.
  assign w_wr_en            = LoadEn && !Reset && addr_in_range(LoadAddr, DEPTH);
  assign w_unused_load_lsbs = ^LoadAddr[1:0];

  // Next-state, wait counter and read-strobe decode. With LATENCY=0 the read is
  // issued on the accepting edge straight from Address, since nothing is latched yet.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_rd_en      = 1'b0;
    w_rd_idx     = r_idx;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_next_state = RESP;
            w_rd_en      = 1'b1;
            w_rd_idx     = w_req_idx;
          end else begin
            w_next_state = WAIT;
            w_next_count = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (Flush) begin
          w_next_state = IDLE;
        end else if (r_count == '0) begin
          w_next_state = RESP;
          w_rd_en      = 1'b1;
        end else begin
          w_next_count = r_count - CNT_W'(1);
        end
      end
      RESP: begin
        if (Flush || RespReady) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State, handshake flags and latched request fields.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_idx        <= '0;
    end else begin
      r_state      <= w_next_state;
      r_count      <= w_next_count;
      r_req_ready  <= (w_next_state == IDLE);
      r_resp_valid <= (w_next_state == RESP);
      if (w_accept) begin
        r_idx <= w_req_idx;
        r_err <= w_req_err;
      end
    end
  end

  mem_word_array #(
    .DEPTH    (DEPTH),
    .INIT_NOP (INIT_NOP)
  ) u_mem (
    .clk     (Clk),
    .rst     (Reset),
    .rd_en   (w_rd_en),
    .rd_idx  (w_rd_idx),
    .rd_data (w_rd_data),
    .wr_en   (w_wr_en),
    .wr_idx  (LoadAddr[IDX_W+1:2]),
    .wr_data (LoadData)
  );

  assign ReqReady    = r_req_ready;
  assign RespValid   = r_resp_valid;
  assign AddrError   = r_err;
  assign Instruction = r_err ? NOP_WORD : w_rd_data;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
module tb_instr_mem_responder;

  logic        clk;
  logic        Reset, ReqValid, Flush, RespReady, LoadEn;
  logic [31:0] Address, LoadAddr, LoadData;
  logic        ReqReady, RespValid, AddrError;
  logic [31:0] Instruction;

  logic        z_Reset, z_ReqValid, z_Flush, z_RespReady, z_LoadEn;
  logic [31:0] z_Address, z_LoadAddr, z_LoadData;
  logic        z_ReqReady, z_RespValid, z_AddrError;
  logic [31:0] z_Instruction;

  int n_pass  = 0;
  int n_total = 0;

  instr_mem_responder #(.DEPTH(1024), .LATENCY(2), .INIT_NOP(1)) dut (
    .Clk(clk), .Reset(Reset), .ReqValid(ReqValid), .Address(Address),
    .ReqReady(ReqReady), .Flush(Flush), .RespValid(RespValid),
    .RespReady(RespReady), .Instruction(Instruction), .AddrError(AddrError),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData)
  );

  instr_mem_responder #(.DEPTH(16), .LATENCY(0), .INIT_NOP(1)) dut_z (
    .Clk(clk), .Reset(z_Reset), .ReqValid(z_ReqValid), .Address(z_Address),
    .ReqReady(z_ReqReady), .Flush(z_Flush), .RespValid(z_RespValid),
    .RespReady(z_RespReady), .Instruction(z_Instruction), .AddrError(z_AddrError),
    .LoadEn(z_LoadEn), .LoadAddr(z_LoadAddr), .LoadData(z_LoadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    LoadEn = 1'b1; LoadAddr = addr; LoadData = data;
    tick();
    LoadEn = 1'b0;
  endtask

  // Fetch with RespReady held high on the LATENCY=2 instance.
  task automatic fetch(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp_ins, input logic exp_err);
    ReqValid = 1'b1; Address = addr; RespReady = 1'b1;
    tick();
    ReqValid = 1'b0;
    check({tag, "_w0_valid"}, 32'(RespValid), 32'd0);
    check({tag, "_w0_ready"}, 32'(ReqReady), 32'd0);
    tick();
    check({tag, "_w1_valid"}, 32'(RespValid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(RespValid), 32'd1);
    check({tag, "_instr"}, Instruction, exp_ins);
    check({tag, "_err"}, 32'(AddrError), 32'(exp_err));
    check({tag, "_resp_ready"}, 32'(ReqReady), 32'd0);
    tick();
    check({tag, "_done_valid"}, 32'(RespValid), 32'd0);
    check({tag, "_done_ready"}, 32'(ReqReady), 32'd1);
  endtask

  initial begin
    Reset = 1'b1; ReqValid = 1'b0; Flush = 1'b0; RespReady = 1'b0; LoadEn = 1'b0;
    Address = '0; LoadAddr = '0; LoadData = '0;
    z_Reset = 1'b1; z_ReqValid = 1'b0; z_Flush = 1'b0; z_RespReady = 1'b0; z_LoadEn = 1'b0;
    z_Address = '0; z_LoadAddr = '0; z_LoadData = '0;

    tick();
    tick();
    check("rst_ready", 32'(ReqReady), 32'd0);
    check("rst_valid", 32'(RespValid), 32'd0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_err", 32'(AddrError), 32'd0);
    Reset = 1'b0; z_Reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(ReqReady), 32'd1);

    load(32'h0000_0040, 32'h2008_0005);
    load(32'h0000_0044, 32'h8C09_0004);
    load(32'h0000_004B, 32'h1111_1111);   // low bits ignored -> word 0x48
    load(32'h0000_0FFC, 32'h1234_5678);
    load(32'h0000_1000, 32'hDEAD_BEEF);   // out of range, must not alias word 0

    fetch("good40", 32'h0000_0040, 32'h2008_0005, 1'b0);
    fetch("mis42", 32'h0000_0042, 32'h0000_0000, 1'b1);
    fetch("oor1000", 32'h0000_1000, 32'h0000_0000, 1'b1);
    fetch("last", 32'h0000_0FFC, 32'h1234_5678, 1'b0);
    fetch("word0", 32'h0000_0000, 32'h0000_0000, 1'b0);
    fetch("lsb48", 32'h0000_0048, 32'h1111_1111, 1'b0);

    // Back-pressure: response held, no new acceptance while RESP.
    ReqValid = 1'b1; Address = 32'h0000_0044; RespReady = 1'b0;
    tick();
    Address = 32'h0000_0048;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(RespValid), 32'd1);
      check("hold_instr", Instruction, 32'h8C09_0004);
      check("hold_ready", 32'(ReqReady), 32'd0);
      tick();
    end
    ReqValid = 1'b0; RespReady = 1'b1;
    tick();
    check("hold_rel_valid", 32'(RespValid), 32'd0);
    check("hold_rel_ready", 32'(ReqReady), 32'd1);

    // Flush one cycle after acceptance.
    ReqValid = 1'b1; Address = 32'h0000_0040;
    tick();
    ReqValid = 1'b0; Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush_ready", 32'(ReqReady), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("flush_no_resp", 32'(RespValid), 32'd0);
      tick();
    end
    fetch("after_flush", 32'h0000_0044, 32'h8C09_0004, 1'b0);

    // Load collides with the storage read: old word returned, then new word.
    ReqValid = 1'b1; Address = 32'h0000_0040;
    tick();
    ReqValid = 1'b0;
    tick();
    LoadEn = 1'b1; LoadAddr = 32'h0000_0040; LoadData = 32'hAAAA_5555;
    tick();
    LoadEn = 1'b0;
    check("coll_valid", 32'(RespValid), 32'd1);
    check("coll_old", Instruction, 32'h2008_0005);
    tick();
    fetch("coll_new", 32'h0000_0040, 32'hAAAA_5555, 1'b0);

    // Reset while in WAIT, with a load in the same cycle that must be dropped.
    ReqValid = 1'b1; Address = 32'h0000_0040;
    tick();
    ReqValid = 1'b0; Reset = 1'b1;
    LoadEn = 1'b1; LoadAddr = 32'h0000_0040; LoadData = 32'h0BAD_F00D;
    tick();
    Reset = 1'b0; LoadEn = 1'b0;
    check("rstw_valid", 32'(RespValid), 32'd0);
    check("rstw_ready", 32'(ReqReady), 32'd0);
    check("rstw_instr", Instruction, 32'h0);
    check("rstw_err", 32'(AddrError), 32'd0);
    tick();
    check("rstw_ready_back", 32'(ReqReady), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("rstw_no_resp", 32'(RespValid), 32'd0);
      tick();
    end
    fetch("rstw_refetch", 32'h0000_0040, 32'hAAAA_5555, 1'b0);

    // LATENCY=0 instance: response visible one cycle after acceptance.
    z_LoadEn = 1'b1; z_LoadAddr = 32'h0000_0008; z_LoadData = 32'hCAFE_F00D;
    tick();
    z_LoadEn = 1'b0;
    z_ReqValid = 1'b1; z_Address = 32'h0000_0008; z_RespReady = 1'b1;
    tick();
    z_ReqValid = 1'b0;
    check("z_valid", 32'(z_RespValid), 32'd1);
    check("z_instr", z_Instruction, 32'hCAFE_F00D);
    check("z_err", 32'(z_AddrError), 32'd0);
    check("z_ready_busy", 32'(z_ReqReady), 32'd0);
    tick();
    check("z_done_valid", 32'(z_RespValid), 32'd0);
    check("z_done_ready", 32'(z_ReqReady), 32'd1);
    z_ReqValid = 1'b1; z_Address = 32'h0000_0040;
    tick();
    z_ReqValid = 1'b0;
    check("z_oor_valid", 32'(z_RespValid), 32'd1);
    check("z_oor_err", 32'(z_AddrError), 32'd1);
    check("z_oor_instr", z_Instruction, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
